mcd_ssd_rd_gate: RTL and testbench

//  Store-and-forward gate between SATA read-data converter and memcached read-data port.

---
 rtl/mcd_ssd_rd_gate.sv | 175 +++++++++++++++++
 tb/tb_mcd_ssd_rd_gate.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcd_ssd_rd_gate.sv
// rtl/mcd_ssd_rd_gate.sv - store-and-forward read-data gate between SATA converter and memcached port
// Optional statistics counters enabled by defining MCD_RDGATE_STATS_EN.
module mcd_ssd_rd_gate #(
    parameter int DW       = 32,
    parameter int DEPTH    = 2048,
    parameter int LQ_DEPTH = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic          clk,
    input  logic          nReset,
    input  logic [15:0]   len_data,
    input  logic          len_valid,
    output logic          len_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          fault,
    output logic          idle
`ifdef MCD_RDGATE_STATS_EN
    ,
    output logic [15:0]   stat_cmds,
    output logic [15:0]   stat_faults
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LQ_DEPTH);
    localparam logic [15:0] TO_M1 = 16'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_PUSH  = 3'd2;
    localparam logic [2:0] S_ZERO  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]    state;
    logic [15:0]   cur_len, cnt, dcnt, timer;

    logic [15:0]   lq_mem [LQ_DEPTH];
    logic [LW:0]   lq_wp, lq_rp;
    logic [DW-1:0] f_mem [DEPTH];
    logic [AW:0]   f_wp, f_rp;

    logic lq_empty, lq_full, lq_push, lq_pop, fifo_empty;
    logic in_acc, out_hs, timer_hit, head_oversize, cur_oversize, fault_evt;
    logic [15:0] lq_head;

    assign lq_empty   = (lq_wp == lq_rp);
    assign lq_full    = (lq_wp[LW] != lq_rp[LW]) && (lq_wp[LW-1:0] == lq_rp[LW-1:0]);
    assign lq_head    = lq_mem[lq_rp[LW-1:0]];
    assign lq_push    = len_valid & ~lq_full;
    assign lq_pop     = (state == S_IDLE) & ~lq_empty;
    assign fifo_empty = (f_wp == f_rp);

    assign head_oversize = {16'b0, lq_head} > 32'(DEPTH);
    assign cur_oversize  = {16'b0, cur_len} > 32'(DEPTH);
    assign timer_hit     = (TIMEOUT != 0) && (timer == TO_M1);

    assign len_ready = ~lq_full;
    // in_ready depends only on state and counters, never on out_ready
    assign in_ready  = nReset & ((state == S_FILL) | (state == S_ZERO) |
                                 ((state == S_DRAIN) & (dcnt < cur_len)) |
                                 ((state == S_IDLE) & lq_empty));
    assign in_acc    = in_valid & in_ready;

    assign out_valid = ((state == S_PUSH) & ~fifo_empty) | (state == S_ZERO);
    assign out_last  = out_valid & (cnt == cur_len - 16'd1);
    assign out_data  = (state == S_PUSH) ? f_mem[f_rp[AW-1:0]] : '0;
    assign out_hs    = out_valid & out_ready;
    assign idle      = (state == S_IDLE) & lq_empty & fifo_empty;

    assign fault_evt = ((state == S_IDLE) & lq_empty & in_valid) |
                       (lq_pop & head_oversize) |
                       ((state == S_FILL) & ~in_acc & timer_hit);

    always_ff @(posedge clk) begin
        if (lq_push) lq_mem[lq_wp[LW-1:0]] <= len_data;
        if ((state == S_FILL) && in_acc) f_mem[f_wp[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state   <= S_IDLE;
            cur_len <= '0;
            cnt     <= '0;
            dcnt    <= '0;
            timer   <= '0;
            lq_wp   <= '0;
            lq_rp   <= '0;
            f_wp    <= '0;
            f_rp    <= '0;
            fault   <= 1'b0;
        end else begin
            fault <= fault_evt;
            if (lq_push) lq_wp <= lq_wp + 1'b1;
            if (lq_pop)  lq_rp <= lq_rp + 1'b1;
            case (state)
                S_IDLE: begin
                    if (lq_pop) begin
                        cur_len <= lq_head;
                        cnt     <= '0;
                        dcnt    <= '0;
                        timer   <= '0;
                        if (lq_head == 16'd0) state <= S_IDLE;
                        else if (head_oversize) state <= S_ZERO;
                        else state <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (in_acc) begin
                        f_wp  <= f_wp + 1'b1;
                        timer <= '0;
                        if (cnt + 16'd1 == cur_len) begin
                            cnt   <= '0;
                            state <= S_PUSH;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end else if (timer_hit) begin
                        // discard the partial burst; a zero burst replaces it
                        f_rp  <= f_wp;
                        cnt   <= '0;
                        state <= S_ZERO;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_PUSH: begin
                    if (out_hs) begin
                        f_rp <= f_rp + 1'b1;
                        cnt  <= cnt + 16'd1;
                        if (out_last) state <= S_IDLE;
                    end
                end
                S_ZERO: begin
                    if (in_acc && dcnt != 16'hFFFF) dcnt <= dcnt + 16'd1;
                    timer <= '0;
                    if (out_hs) begin
                        cnt <= cnt + 16'd1;
                        if (out_last) state <= cur_oversize ? S_DRAIN : S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (dcnt >= cur_len) begin
                        state <= S_IDLE;
                    end else if (in_acc) begin
                        dcnt  <= dcnt + 16'd1;
                        timer <= '0;
                        if (dcnt + 16'd1 == cur_len) state <= S_IDLE;
                    end else if (timer_hit) begin
                        state <= S_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MCD_RDGATE_STATS_EN
    always_ff @(posedge clk) begin
        if (!nReset) begin
            stat_cmds   <= '0;
            stat_faults <= '0;
        end else begin
            if (lq_pop && stat_cmds != 16'hFFFF) stat_cmds <= stat_cmds + 16'd1;
            if (fault_evt && stat_faults != 16'hFFFF) stat_faults <= stat_faults + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mcd_ssd_rd_gate.sv
// tb/tb_mcd_ssd_rd_gate.sv - directed self-checking bench for mcd_ssd_rd_gate
module tb_mcd_ssd_rd_gate;
    localparam int DW = 32;
    localparam int DEPTH = 16;
    localparam int LQ = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    logic [15:0] len_data = '0;
    logic len_valid = 1'b0;
    logic len_ready;
    logic [DW-1:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [DW-1:0] out_data;
    logic out_valid;
    logic out_ready = 1'b0;
    logic out_last;
    logic fault;
    logic idle;

    int vectors = 0;
    int errors = 0;
    int fault_pulses = 0;

    mcd_ssd_rd_gate #(.DW(DW), .DEPTH(DEPTH), .LQ_DEPTH(LQ), .TIMEOUT(TO)) dut (
        .clk(clk), .nReset(nReset),
        .len_data(len_data), .len_valid(len_valid), .len_ready(len_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .fault(fault), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (fault === 1'b1) fault_pulses++;

    task automatic push_len(input logic [15:0] l);
        len_data = l;
        len_valid = 1'b1;
        @(negedge clk);
        len_valid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, output bit ok);
        ok = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int n = 0; n < 300 && !ok; n++) begin
            if (out_valid === 1'b1) ok = 1'b1;
            else begin cycles++; @(negedge clk); end
        end
    endtask

    task automatic test_reset;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got %b want 0", out_last); end
        vectors++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
        vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        vectors++; if (len_ready !== 1'b1) begin errors++; $display("FAIL rst_len_ready got %b want 1", len_ready); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b want 1", idle); end
        nReset = 1'b1;
        @(negedge clk);
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        logic [DW-1:0] w [4];
        bit ok;
        w[0] = 32'hA000_000A; w[1] = 32'hB000_000B; w[2] = 32'hC000_000C; w[3] = 32'hD000_000D;
        out_ready = 1'b1;
        push_len(16'd4);
        send_word(w[0], ok);
        vectors++; if (!ok) begin errors++; $display("FAIL basic_accept0 got 0 want 1"); end
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_fill_valid got %b want 0", out_valid); end
        for (int i = 1; i < 4; i++) send_word(w[i], ok);
        for (int i = 0; i < 4; i++) begin
            vectors++; if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 3))
                begin errors++; $display("FAIL basic_word%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out_valid, out_data, out_last, w[i], (i == 3)); end
            @(negedge clk);
        end
        vectors++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL basic_end got v=%b idle=%b want v=0 idle=1", out_valid, idle); end
    endtask

    task automatic test_multi;
        logic [DW-1:0] w [5];
        bit ok;
        int f0;
        f0 = fault_pulses;
        for (int i = 0; i < 5; i++) w[i] = 32'h1111_0000 + i;
        out_ready = 1'b1;
        push_len(16'd2); push_len(16'd0); push_len(16'd3);
        send_word(w[0], ok); send_word(w[1], ok);
        for (int i = 0; i < 2; i++) begin
            vectors++; if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 1))
                begin errors++; $display("FAIL multi_a%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out_valid, out_data, out_last, w[i], (i == 1)); end
            @(negedge clk);
        end
        for (int i = 2; i < 5; i++) send_word(w[i], ok);
        for (int i = 2; i < 5; i++) begin
            vectors++; if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 4))
                begin errors++; $display("FAIL multi_b%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, out_valid, out_data, out_last, w[i], (i == 4)); end
            @(negedge clk);
        end
        @(negedge clk);
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL multi_idle got %b want 1", idle); end
        vectors++; if (fault_pulses !== f0) begin errors++; $display("FAIL multi_faults got %0d want %0d", fault_pulses, f0); end
    endtask

    task automatic test_timeout;
        bit ok;
        int f0, cyc;
        f0 = fault_pulses;
        out_ready = 1'b1;
        push_len(16'd3);
        send_word(32'h5555_0001, ok); send_word(32'h5555_0002, ok);
        wait_valid(ok, cyc);
        vectors++; if (!ok || cyc != TO) begin errors++; $display("FAIL timeout_latency got ok=%b cyc=%0d want ok=1 cyc=%0d", ok, cyc, TO); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (out_valid !== 1'b1 || out_data !== '0 || out_last !== (i == 2))
                begin errors++; $display("FAIL timeout_zero%0d got v=%b d=%h l=%b want v=1 d=0 l=%b", i, out_valid, out_data, out_last, (i == 2)); end
            @(negedge clk);
        end
        @(negedge clk);
        vectors++; if (idle !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL timeout_idle got idle=%b v=%b want 1 0", idle, out_valid); end
        vectors++; if (fault_pulses !== f0 + 1) begin errors++; $display("FAIL timeout_faults got %0d want %0d", fault_pulses, f0 + 1); end
    endtask

    task automatic test_oversize;
        bit ok;
        int f0, cyc, bad_zero, bad_drop;
        f0 = fault_pulses;
        bad_zero = 0;
        bad_drop = 0;
        out_ready = 1'b1;
        push_len(16'(DEPTH + 4));
        wait_valid(ok, cyc);
        vectors++; if (!ok) begin errors++; $display("FAIL over_start got 0 want 1"); end
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (out_valid !== 1'b1 || out_data !== '0 || out_last !== (i == DEPTH + 3)) bad_zero++;
            @(negedge clk);
        end
        vectors++; if (bad_zero != 0) begin errors++; $display("FAIL over_zeros got %0d bad words want 0", bad_zero); end
        for (int i = 0; i < DEPTH + 4; i++) begin
            send_word(32'hDEAD_0000 + i, ok);
            if (!ok || out_valid !== 1'b0) bad_drop++;
        end
        vectors++; if (bad_drop != 0) begin errors++; $display("FAIL over_drain got %0d bad drops want 0", bad_drop); end
        push_len(16'd1);
        send_word(32'hCAFE_0001, ok);
        vectors++; if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0001 || out_last !== 1'b1)
            begin errors++; $display("FAIL over_next got v=%b d=%h l=%b want v=1 d=cafe0001 l=1", out_valid, out_data, out_last); end
        @(negedge clk); @(negedge clk);
        vectors++; if (fault_pulses !== f0 + 1) begin errors++; $display("FAIL over_faults got %0d want %0d", fault_pulses, f0 + 1); end
        vectors++; if (idle !== 1'b1) begin errors++; $display("FAIL over_idle got %b want 1", idle); end
    endtask

    task automatic test_overrun;
        bit ok;
        int f0;
        f0 = fault_pulses;
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL overrun_ready got %b want 1", in_ready); end
        send_word(32'hBAD0_BAD0, ok);
        @(negedge clk); @(negedge clk);
        vectors++; if (fault_pulses !== f0 + 1) begin errors++; $display("FAIL overrun_fault got %0d want %0d", fault_pulses, f0 + 1); end
        vectors++; if (idle !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL overrun_state got idle=%b v=%b want 1 0", idle, out_valid); end
    endtask

    task automatic test_stall;
        bit ok;
        int bad;
        bad = 0;
        out_ready = 1'b0;
        push_len(16'd2);
        send_word(32'h7777_0001, ok); send_word(32'h7777_0002, ok);
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || out_data !== 32'h7777_0001 || out_last !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_data !== 32'h7777_0002 || out_last !== 1'b1)
            begin errors++; $display("FAIL stall_second got v=%b d=%h l=%b want v=1 d=77770002 l=1", out_valid, out_data, out_last); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        out_ready = 1'b0;
        push_len(16'd3);
        for (int i = 0; i < 3; i++) send_word(32'h9999_0000 + i, ok);
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b want 1", out_valid); end
        nReset = 1'b0;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL rmid_reset got v=%b idle=%b want 0 1", out_valid, idle); end
        nReset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || idle !== 1'b1)
            begin errors++; $display("FAIL rmid_after got v=%b ir=%b idle=%b want 0 1 1", out_valid, in_ready, idle); end
        push_len(16'd1);
        send_word(32'h4242_4242, ok);
        vectors++; if (out_valid !== 1'b1 || out_data !== 32'h4242_4242 || out_last !== 1'b1)
            begin errors++; $display("FAIL rmid_next got v=%b d=%h l=%b want v=1 d=42424242 l=1", out_valid, out_data, out_last); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset;
        test_basic;
        test_multi;
        test_timeout;
        test_oversize;
        test_overrun;
        test_stall;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
